// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM mux scanner: channel geometry, FSM states,
// and the per-slot output bundle.
package tdm_pkg;

    localparam int NCH       = 8;
    localparam int SEL_W     = 3;
    localparam int DWELL_MAX = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } tdm_state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             obit;
        logic             valid;
        logic             fsync;
        logic             busy;
    } tdm_out_t;

    function automatic int dwell_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic tdm_out_t slot_out(input logic [NCH-1:0] data,
                                          input logic [SEL_W-1:0] sel,
                                          input logic fsync);
        tdm_out_t o;
        o.sel   = sel;
        o.obit  = data[sel];
        o.valid = 1'b1;
        o.fsync = fsync;
        o.busy  = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Dwell + channel counter for the TDM scanner. clr wins over inc; ch only
// advances once per completed dwell period.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] ch,
    output logic             slot_end,
    output logic             frame_end
);

    localparam int             DW_W    = dwell_w(DWELL);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    logic [DW_W-1:0] dwell;

    assign slot_end  = (dwell == DW_LAST);
    assign frame_end = slot_end && (ch == SEL_W'(NCH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
            ch    <= '0;
        end else if (clr) begin
            dwell <= '0;
            ch    <= '0;
        end else if (inc) begin
            if (slot_end) begin
                dwell <= '0;
                ch    <= ch + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_scanner.sv
// TDM transmitter: snapshots iData at frame start and serialises it one channel per
// slot on oBit with select {A,B,C}. Optional oParity output under TDM_PARITY_EN.
module tdm_mux_scanner
    import tdm_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] iData,
    input  logic           start,
    output logic           A,
    output logic           B,
    output logic           C,
    output logic           oBit,
    output logic           oValid,
    output logic           frame_sync,
    output logic           busy,
`ifdef TDM_PARITY_EN
    output logic           oParity,
`endif
    output logic           done
);

    tdm_state_t       state;
    logic [NCH-1:0]   snap;
    tdm_out_t         q;
    logic             done_q;
    logic [SEL_W-1:0] ch;
    logic             slot_end;
    logic             frame_end;
    logic             inc;
    logic             clr;

    // Counter is parked at 0 while idle and rewinds at every frame boundary.
    assign inc = (state == SCAN);
    assign clr = (state == IDLE) || frame_end;

    tdm_slot_counter #(.DWELL(DWELL)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc),
        .clr       (clr),
        .ch        (ch),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

`ifdef TDM_PARITY_EN
    logic par_q;
`endif

    // Outputs are built from the counter's next value so every port is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            snap   <= '0;
            q      <= '0;
            done_q <= 1'b0;
`ifdef TDM_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef TDM_PARITY_EN
            par_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        snap  <= iData;
                        q     <= slot_out(iData, '0, 1'b1);
                    end else begin
                        q <= '0;
                    end
                end
                SCAN: begin
                    if (frame_end) begin
                        done_q <= 1'b1;
`ifdef TDM_PARITY_EN
                        par_q  <= ^snap;
`endif
                        if (start) begin
                            snap <= iData;
                            q    <= slot_out(iData, '0, 1'b1);
                        end else begin
                            state <= IDLE;
                            q     <= '0;
                        end
                    end else if (slot_end) begin
                        q <= slot_out(snap, ch + 1'b1, 1'b0);
                    end else begin
                        q <= slot_out(snap, ch, 1'b0);
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= '0;
                end
            endcase
        end
    end

    assign {A, B, C}  = q.sel;
    assign oBit       = q.obit;
    assign oValid     = q.valid;
    assign frame_sync = q.fsync;
    assign busy       = q.busy;
    assign done       = done_q;
`ifdef TDM_PARITY_EN
    assign oParity    = par_q;
`endif

endmodule
